hex_capture: RTL

HEX_CAPTURE -- requirements
Module: hex_capture

---
 rtl/hex_capture_if.sv | 30 +++
 rtl/hex_capture.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/hex_capture_if.sv
// hex_capture_if: bundles the eight seven-segment inputs, the capture request
// and the capture result outputs of hex_capture into a single port.
interface hex_capture_if;
  logic [6:0]  HEX0;
  logic [6:0]  HEX1;
  logic [6:0]  HEX2;
  logic [6:0]  HEX3;
  logic [6:0]  HEX4;
  logic [6:0]  HEX5;
  logic [6:0]  HEX6;
  logic [6:0]  HEX7;
  logic        capture_req;
  logic        busy;
  logic        valid;
  logic [31:0] value;
  logic [7:0]  err_mask;
  logic        timeout;

  // The master drives the displays and requests captures.
  modport master (
    output HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7, capture_req,
    input  busy, valid, value, err_mask, timeout
  );

  // The slave (the capture engine) reads the displays and reports results.
  modport slave (
    input  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7, capture_req,
    output busy, valid, value, err_mask, timeout
  );
endinterface

// File: rtl/hex_capture.sv
// hex_capture: snapshots eight active-low seven-segment digits, decodes them
// one per cycle into a 32-bit hex value, then waits until the live inputs
// have matched the snapshot for STABLE_CYCLES consecutive cycles. A change
// during that wait restarts the snapshot, up to MAX_RETRY times, after which
// the capture finishes with timeout set.
module hex_capture #(
  parameter int STABLE_CYCLES = 4,
  parameter int MAX_RETRY     = 3
) (
  input  logic          clk,
  input  logic          rst,
  hex_capture_if.slave  bus
);

  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [7:0]         STABLE_LIMIT = 8'(STABLE_CYCLES);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    IDLE,
    SNAP,
    SCAN,
    STABLE,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [6:0]         live_d   [8];
  logic [6:0]         shadow_d [8];
  logic [2:0]         digit_idx;
  logic [7:0]         stable_cnt;
  logic [RETRY_W-1:0] retry_cnt;
  logic [31:0]        value_q;
  logic [7:0]         err_q;
  logic               timeout_q;

  logic               live_match;
  logic [6:0]         scan_pat;
  logic [3:0]         scan_nib;
  logic               scan_err;
  logic               stable_reached;
  logic               retry_left;

  // Live digits as an array so they line up index-for-index with the shadow.
  assign live_d = '{bus.HEX0, bus.HEX1, bus.HEX2, bus.HEX3,
                    bus.HEX4, bus.HEX5, bus.HEX6, bus.HEX7};

  // The digit being decoded in the current scan cycle always comes from the shadow.
  assign scan_pat = shadow_d[digit_idx];

  // The counter is compared one step ahead so DONE is entered on the edge
  // that completes the final matching cycle.
  assign stable_reached = ((stable_cnt + 8'd1) == STABLE_LIMIT);
  assign retry_left     = (retry_cnt < RETRY_LIMIT);

  // Whole-display compare of live inputs against the snapshot.
  always_comb begin
    live_match = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (live_d[i] != shadow_d[i]) begin
        live_match = 1'b0;
      end
    end
  end

  // Seven-segment to nibble decode; unknown patterns (blank included) give 0 and an error flag.
  always_comb begin
    scan_nib = 4'h0;
    scan_err = 1'b0;
    case (scan_pat)
      7'h40: scan_nib = 4'h0;
      7'h79: scan_nib = 4'h1;
      7'h24: scan_nib = 4'h2;
      7'h30: scan_nib = 4'h3;
      7'h19: scan_nib = 4'h4;
      7'h12: scan_nib = 4'h5;
      7'h02: scan_nib = 4'h6;
      7'h78: scan_nib = 4'h7;
      7'h00: scan_nib = 4'h8;
      7'h10: scan_nib = 4'h9;
      7'h08: scan_nib = 4'hA;
      7'h03: scan_nib = 4'hB;
      7'h46: scan_nib = 4'hC;
      7'h21: scan_nib = 4'hD;
      7'h06: scan_nib = 4'hE;
      7'h0E: scan_nib = 4'hF;
      default: begin
        scan_nib = 4'h0;
        scan_err = 1'b1;
      end
    endcase
  end

  // Control FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; capture_req only matters while idle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.capture_req) begin
          state_next = SNAP;
        end
      end
      SNAP: begin
        state_next = SCAN;
      end
      SCAN: begin
        if (digit_idx == 3'd7) begin
          state_next = STABLE;
        end
      end
      STABLE: begin
        if (live_match) begin
          if (stable_reached) begin
            state_next = DONE;
          end
        end else if (retry_left) begin
          state_next = SNAP;
        end else begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: snapshot, per-digit decode, stability and retry counting.
  // Results are never cleared on leaving DONE; they are simply overwritten
  // digit by digit during the next scan.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_d   <= '{default: 7'h00};
      digit_idx  <= 3'd0;
      stable_cnt <= 8'd0;
      retry_cnt  <= '0;
      value_q    <= 32'h0;
      err_q      <= 8'h00;
      timeout_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.capture_req) begin
            retry_cnt <= '0;
            timeout_q <= 1'b0;
          end
        end
        SNAP: begin
          shadow_d   <= live_d;
          digit_idx  <= 3'd0;
          stable_cnt <= 8'd0;
        end
        SCAN: begin
          value_q[{digit_idx, 2'b00} +: 4] <= scan_nib;
          err_q[digit_idx]                 <= scan_err;
          digit_idx                        <= digit_idx + 3'd1;
        end
        STABLE: begin
          if (live_match) begin
            stable_cnt <= stable_cnt + 8'd1;
          end else if (retry_left) begin
            retry_cnt <= retry_cnt + 1'b1;
          end else begin
            timeout_q <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.valid    = (state == DONE);
  assign bus.value    = value_q;
  assign bus.err_mask = err_q;
  assign bus.timeout  = timeout_q;

endmodule
